// File: rtl/csr_pkg.sv
// Shared machine-mode CSR definitions for the RV32I softcore.
//   - CSR address constants for the trap-owned registers
//   - mcause exception / interrupt code constants
//   - trap sequencer FSM state encoding
// Used by trap_unit, trap_prio and csrrf.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC_ADDR = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;

  // mcause exception codes (interrupt flag lives in mcause[31])
  localparam logic [3:0] CODE_IMIS     = 4'd0;
  localparam logic [3:0] CODE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CODE_BREAK    = 4'd3;
  localparam logic [3:0] CODE_LMIS     = 4'd4;
  localparam logic [3:0] CODE_SMIS     = 4'd6;
  localparam logic [3:0] CODE_ECALL_M  = 4'd11;
  localparam logic [3:0] CODE_MEXT_IRQ = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } state_e;

endpackage

// File: rtl/trap_prio.sv
// Combinational trap priority encoder.
// Inputs : ex_valid, the exception sources, csrrf's exception_machine_trap /
//          exception_permission, irq_ext and the current MIE.
// Outputs: take (a trap must be entered), is_irq (winner is the interrupt),
//          code (mcause exception code of the winner).
// Exceptions are qualified by ex_valid and always beat the interrupt.
module trap_prio
  import csr_pkg::*;
(
  input  logic       ex_valid,
  input  logic       exc_ill,
  input  logic       exc_ecall,
  input  logic       exc_ebreak,
  input  logic       exc_imis,
  input  logic       exc_lmis,
  input  logic       exc_smis,
  input  logic       exception_machine_trap,
  input  logic       exception_permission,
  input  logic       irq_ext,
  input  logic       mie,
  output logic       take,
  output logic       is_irq,
  output logic [3:0] code
);

  always_comb begin
    // NOTE: every output gets a default first, so no path through the
    // if-chain leaves one unassigned and no latch is inferred.
    take   = 1'b1;
    is_irq = 1'b0;
    code   = '0;
    if (ex_valid && exc_ebreak)                          code = CODE_BREAK;
    else if (ex_valid && exc_imis)                       code = CODE_IMIS;
    else if (ex_valid && (exc_ill || exception_permission)) code = CODE_ILLEGAL;
    else if (ex_valid && exc_ecall)                      code = CODE_ECALL_M;
    else if (ex_valid && exc_smis)                       code = CODE_SMIS;
    else if (ex_valid && exc_lmis)                       code = CODE_LMIS;
    else if (ex_valid && exception_machine_trap)         code = CODE_ECALL_M;
    else if (irq_ext && mie) begin
      is_irq = 1'b1;
      code   = CODE_MEXT_IRQ;
    end else begin
      take = 1'b0;
    end
  end

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap sequencer for the RV32I softcore.
// Owns mepc, mcause, mtval, mtvec and mstatus.MIE/MPIE; sequences trap entry
// and mret by flushing the pipeline and handing a new PC to fetch.
// Ports:
//   clk, resetb            clock, asynchronous active-low reset
//   ex_pc, ex_valid        instruction in execute
//   exc_*                  core exception sources; exc_badaddr for misaligns
//   exception_machine_trap, exception_permission   from csrrf
//   irq_ext                level external interrupt, masked by MIE
//   mret                   mret in execute
//   csr_addr/we/wdata      CSR write port forwarded by csrrf
//   csr_rdata              combinational read of the owned CSRs (0 otherwise)
//   flush, redirect_valid, redirect_pc, redirect_ready   fetch redirect handshake
// Build option: TRAP_UNIT_VECTORED_EN makes mtvec[0] writable and sends
// interrupts to base + 4*cause when mtvec[0] is set.
module trap_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0010,
  parameter logic [11:0] CSR_MEPC    = CSR_MEPC_ADDR
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [31:0] ex_pc,
  input  logic        ex_valid,
  input  logic        exc_ill,
  input  logic        exc_ecall,
  input  logic        exc_ebreak,
  input  logic        exc_imis,
  input  logic        exc_lmis,
  input  logic        exc_smis,
  input  logic [31:0] exc_badaddr,
  input  logic        exception_machine_trap,
  input  logic        exception_permission,
  input  logic        irq_ext,
  input  logic        mret,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  state_e      state;
  logic [31:0] mepc, mcause, mtval, mtvec;
  logic        mie, mpie;

  logic        take, is_irq;
  logic [3:0]  code;

  trap_prio u_prio (
    .ex_valid               (ex_valid),
    .exc_ill                (exc_ill),
    .exc_ecall              (exc_ecall),
    .exc_ebreak             (exc_ebreak),
    .exc_imis               (exc_imis),
    .exc_lmis               (exc_lmis),
    .exc_smis               (exc_smis),
    .exception_machine_trap (exception_machine_trap),
    .exception_permission   (exception_permission),
    .irq_ext                (irq_ext),
    .mie                    (mie),
    .take                   (take),
    .is_irq                 (is_irq),
    .code                   (code)
  );

  // Events are only looked at in IDLE; a trap beats mret and CSR writes.
  logic trap_go, mret_go;
  assign trap_go = (state == ST_IDLE) && take;
  assign mret_go = (state == ST_IDLE) && !take && ex_valid && mret;

  logic [31:0] mtvec_base, trap_tval, trap_target, mtvec_wval;
  assign mtvec_base = {mtvec[31:2], 2'b00};

  always_comb begin
    trap_tval = '0;
    if (!is_irq) begin
      case (code)
        CODE_IMIS, CODE_LMIS, CODE_SMIS: trap_tval = exc_badaddr;
        CODE_ILLEGAL:                    trap_tval = ex_pc;
        default:                         trap_tval = '0;
      endcase
    end
  end

`ifdef TRAP_UNIT_VECTORED_EN
  assign mtvec_wval  = {csr_wdata[31:2], 1'b0, csr_wdata[0]};
  assign trap_target = (is_irq && mtvec[0]) ? mtvec_base + {26'b0, code, 2'b00}
                                            : mtvec_base;
`else
  assign mtvec_wval  = {csr_wdata[31:2], 2'b00};
  assign trap_target = mtvec_base;
`endif

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state          <= ST_IDLE;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
      mtvec          <= {MTVEC_RESET[31:2], 2'b00};
      mie            <= 1'b0;
      mpie           <= 1'b1;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values of the others.
      case (state)
        ST_IDLE: begin
          if (trap_go) begin
            mepc           <= ex_pc;
            mcause         <= {is_irq, 27'b0, code};
            mtval          <= trap_tval;
            mpie           <= mie;
            mie            <= 1'b0;
            state          <= ST_TRAP;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= trap_target;
          end else if (mret_go) begin
            mie            <= mpie;
            mpie           <= 1'b1;
            state          <= ST_RET;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= {mepc[31:2], 2'b00};
          end else if (csr_we) begin
            case (csr_addr)
              CSR_MEPC:    mepc   <= {csr_wdata[31:2], 2'b00};
              CSR_MCAUSE:  mcause <= csr_wdata;
              CSR_MTVAL:   mtval  <= csr_wdata;
              CSR_MTVEC:   mtvec  <= mtvec_wval;
              CSR_MSTATUS: begin
                mie  <= csr_wdata[3];
                mpie <= csr_wdata[7];
              end
              default: ;
            endcase
          end
        end
        ST_TRAP, ST_RET: begin
          if (redirect_ready) begin
            state          <= ST_IDLE;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MEPC:    csr_rdata = mepc;
      CSR_MCAUSE:  csr_rdata = mcause;
      CSR_MTVAL:   csr_rdata = mtval;
      CSR_MTVEC:   csr_rdata = mtvec;
      CSR_MSTATUS: csr_rdata = {24'b0, mpie, 3'b0, mie, 3'b0};
      default:     csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: directed scenarios plus randomized
// traffic against a behavioural model of the trap rules.
module tb_trap_unit;

  logic        clk = 1'b0;
  logic        resetb;
  logic [31:0] ex_pc, exc_badaddr, csr_wdata, csr_rdata, redirect_pc;
  logic        ex_valid, exc_ill, exc_ecall, exc_ebreak, exc_imis, exc_lmis, exc_smis;
  logic        exception_machine_trap, exception_permission, irq_ext, mret;
  logic [11:0] csr_addr;
  logic        csr_we, flush, redirect_valid, redirect_ready;

  int n_vec = 0;
  int n_err = 0;

`ifdef TRAP_UNIT_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  always #5 clk = ~clk;

  trap_unit dut (
    .clk(clk), .resetb(resetb), .ex_pc(ex_pc), .ex_valid(ex_valid),
    .exc_ill(exc_ill), .exc_ecall(exc_ecall), .exc_ebreak(exc_ebreak),
    .exc_imis(exc_imis), .exc_lmis(exc_lmis), .exc_smis(exc_smis),
    .exc_badaddr(exc_badaddr), .exception_machine_trap(exception_machine_trap),
    .exception_permission(exception_permission), .irq_ext(irq_ext), .mret(mret),
    .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mepc, m_mcause, m_mtval, m_mtvec, m_target;
  bit          m_mie, m_mpie, m_busy;

  task automatic model_reset();
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mtvec = 32'h10;
    m_mie = 0; m_mpie = 1; m_busy = 0; m_target = 0;
  endtask

  // Applies the trap rules to the inputs present just before a clock edge.
  task automatic model_update();
    bit   conds [7];
    int   codes [7] = '{3, 0, 2, 11, 6, 4, 11};
    int   win = -1;
    bit   irq;
    if (m_busy) begin
      if (redirect_ready) m_busy = 0;
      return;
    end
    conds = '{exc_ebreak, exc_imis, exc_ill || exception_permission, exc_ecall,
              exc_smis, exc_lmis, exception_machine_trap};
    if (ex_valid)
      for (int i = 0; i < 7; i++) if (conds[i] && win < 0) win = codes[i];
    irq = (win < 0) && irq_ext && m_mie;
    if (win >= 0 || irq) begin
      m_mepc   = ex_pc;
      m_mcause = irq ? 32'h8000_000B : win;
      if (!irq && (win == 0 || win == 4 || win == 6)) m_mtval = exc_badaddr;
      else if (!irq && win == 2)                      m_mtval = ex_pc;
      else                                            m_mtval = 0;
      m_mpie   = m_mie;
      m_mie    = 0;
      m_busy   = 1;
      m_target = m_mtvec & ~32'h3;
      if (VEC && irq && m_mtvec[0]) m_target = m_target + 4 * (m_mcause & 32'h7FFF_FFFF);
    end else if (ex_valid && mret) begin
      m_mie    = m_mpie;
      m_mpie   = 1;
      m_busy   = 1;
      m_target = m_mepc & ~32'h3;
    end else if (csr_we) begin
      case (csr_addr)
        12'h341: m_mepc   = csr_wdata & ~32'h3;
        12'h342: m_mcause = csr_wdata;
        12'h343: m_mtval  = csr_wdata;
        12'h305: m_mtvec  = csr_wdata & (VEC ? ~32'h2 : ~32'h3);
        12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] model_csr(input logic [11:0] a);
    case (a)
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h305: return m_mtvec;
      12'h300: return {24'b0, m_mpie, 3'b0, m_mie, 3'b0};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    ex_pc = 0; ex_valid = 0; exc_ill = 0; exc_ecall = 0; exc_ebreak = 0;
    exc_imis = 0; exc_lmis = 0; exc_smis = 0; exc_badaddr = 0;
    exception_machine_trap = 0; exception_permission = 0; irq_ext = 0;
    mret = 0; csr_addr = 0; csr_we = 0; csr_wdata = 0; redirect_ready = 0;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic read_csr(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic write_csr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1; csr_addr = a; csr_wdata = d;
    step();
    csr_we = 0;
  endtask

  // Lets fetch accept a pending redirect.
  task automatic drain();
    redirect_ready = 1;
    step();
    redirect_ready = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    idle_inputs();
    resetb = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetb = 1;
    #1;
    read_csr(12'h305, d);
    n_vec++; if (d !== 32'h10) begin n_err++; $display("FAIL reset_mtvec: got %h want %h", d, 32'h10); end
    read_csr(12'h300, d);
    n_vec++; if (d !== 32'h80) begin n_err++; $display("FAIL reset_mstatus: got %h want %h", d, 32'h80); end
    n_vec++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
      n_err++; $display("FAIL reset_outputs: got flush=%b rv=%b pc=%h want 0/0/0", flush, redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] d;
    ex_valid = 1; exc_ill = 1; ex_pc = 32'h100;
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h10) begin
        n_err++; $display("FAIL ill_hold[%0d]: got flush=%b rv=%b pc=%h want 1/1/00000010", i, flush, redirect_valid, redirect_pc);
      end
      redirect_ready = (i == 3);
      step();
    end
    redirect_ready = 0;
    n_vec++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin
      n_err++; $display("FAIL ill_release: got flush=%b rv=%b want 0/0", flush, redirect_valid);
    end
    read_csr(12'h341, d);
    n_vec++; if (d !== 32'h100) begin n_err++; $display("FAIL ill_mepc: got %h want %h", d, 32'h100); end
    read_csr(12'h342, d);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL ill_mcause: got %h want %h", d, 32'h2); end
    read_csr(12'h343, d);
    n_vec++; if (d !== 32'h100) begin n_err++; $display("FAIL ill_mtval: got %h want %h", d, 32'h100); end
  endtask

  task automatic test_ecall_smis();
    logic [31:0] d;
    ex_valid = 1; exc_ecall = 1; exc_smis = 1; exc_badaddr = 32'h555; ex_pc = 32'h140;
    step();
    idle_inputs();
    drain();
    read_csr(12'h342, d);
    n_vec++; if (d !== 32'd11) begin n_err++; $display("FAIL ecall_mcause: got %h want %h", d, 32'd11); end
    read_csr(12'h343, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ecall_mtval: got %h want %h", d, 32'h0); end
    ex_valid = 1; exc_smis = 1; exc_badaddr = 32'h203; ex_pc = 32'h180;
    step();
    idle_inputs();
    drain();
    read_csr(12'h342, d);
    n_vec++; if (d !== 32'd6) begin n_err++; $display("FAIL smis_mcause: got %h want %h", d, 32'd6); end
    read_csr(12'h343, d);
    n_vec++; if (d !== 32'h203) begin n_err++; $display("FAIL smis_mtval: got %h want %h", d, 32'h203); end
  endtask

  task automatic test_irq_roundtrip();
    logic [31:0] d;
    write_csr(12'h300, 32'h8);
    irq_ext = 1; ex_pc = 32'h1C4;
    step();
    irq_ext = 0;
    drain();
    read_csr(12'h342, d);
    n_vec++; if (d !== 32'h8000_000B) begin n_err++; $display("FAIL irq_mcause: got %h want %h", d, 32'h8000_000B); end
    read_csr(12'h300, d);
    n_vec++; if (d !== 32'h80) begin n_err++; $display("FAIL irq_mstatus: got %h want %h", d, 32'h80); end
    read_csr(12'h341, d);
    n_vec++; if (d !== 32'h1C4) begin n_err++; $display("FAIL irq_mepc: got %h want %h", d, 32'h1C4); end
    ex_valid = 1; mret = 1; ex_pc = 32'h40;
    step();
    idle_inputs();
    n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C4) begin
      n_err++; $display("FAIL mret_redirect: got rv=%b pc=%h want 1/000001c4", redirect_valid, redirect_pc);
    end
    drain();
    read_csr(12'h300, d);
    n_vec++; if (d !== 32'h88) begin n_err++; $display("FAIL mret_mstatus: got %h want %h", d, 32'h88); end
  endtask

  task automatic test_masked_irq_mepc();
    logic [31:0] d;
    write_csr(12'h300, 32'h0);
    irq_ext = 1;
    step();
    step();
    irq_ext = 0;
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL masked_irq: got flush=%b want 0", flush); end
    write_csr(12'h341, 32'h207);
    read_csr(12'h341, d);
    n_vec++; if (d !== 32'h204) begin n_err++; $display("FAIL mepc_align: got %h want %h", d, 32'h204); end
  endtask

  task automatic test_vectored();
`ifdef TRAP_UNIT_VECTORED_EN
    write_csr(12'h305, 32'h1001);
    write_csr(12'h300, 32'h8);
    irq_ext = 1; ex_pc = 32'h300;
    step();
    irq_ext = 0;
    n_vec++; if (redirect_pc !== 32'h102C) begin n_err++; $display("FAIL vec_irq_pc: got %h want %h", redirect_pc, 32'h102C); end
    drain();
    write_csr(12'h305, 32'h10);
`endif
  endtask

  task automatic test_random();
    logic [11:0] addrs [7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};
    logic [31:0] d;
    for (int it = 0; it < 300; it++) begin
      ex_valid    = $urandom_range(0, 1);
      ex_pc       = $urandom;
      exc_badaddr = $urandom;
      exc_ill     = ($urandom_range(0, 9) == 0);
      exc_ecall   = ($urandom_range(0, 9) == 0);
      exc_ebreak  = ($urandom_range(0, 9) == 0);
      exc_imis    = ($urandom_range(0, 9) == 0);
      exc_lmis    = ($urandom_range(0, 9) == 0);
      exc_smis    = ($urandom_range(0, 9) == 0);
      exception_machine_trap = ($urandom_range(0, 9) == 0);
      exception_permission   = ($urandom_range(0, 9) == 0);
      irq_ext     = ($urandom_range(0, 3) == 0);
      mret        = ($urandom_range(0, 5) == 0);
      csr_we      = ($urandom_range(0, 2) == 0);
      csr_addr    = addrs[$urandom_range(0, 6)];
      csr_wdata   = $urandom;
      redirect_ready = $urandom_range(0, 1);
      step();
      csr_we = 0;
      n_vec++; if (flush !== m_busy || redirect_valid !== m_busy) begin
        n_err++; $display("FAIL rnd_handshake[%0d]: got flush=%b rv=%b want %b", it, flush, redirect_valid, m_busy);
      end
      if (m_busy) begin
        n_vec++; if (redirect_pc !== m_target) begin
          n_err++; $display("FAIL rnd_redirect_pc[%0d]: got %h want %h", it, redirect_pc, m_target);
        end
      end
      for (int k = 0; k < 5; k++) begin
        read_csr(addrs[(it + k) % 7], d);
        n_vec++; if (d !== model_csr(addrs[(it + k) % 7])) begin
          n_err++; $display("FAIL rnd_csr_%h[%0d]: got %h want %h", addrs[(it + k) % 7], it, d, model_csr(addrs[(it + k) % 7]));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_ecall_smis();
    test_irq_roundtrip();
    test_masked_irq_mepc();
    test_vectored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
